// File: rtl/serial_fifo_pkg.sv
// serial_fifo_pkg
// Shared definitions for the serial FIFO controller: status register bit
// positions, TX FSM state encoding and the default FIFO depth.
package serial_fifo_pkg;

    localparam int DEFAULT_DEPTH = 16;

    // Status register bit positions
    localparam int TXNF   = 0;
    localparam int RXNE   = 1;
    localparam int OVR    = 2;
    localparam int TXIDLE = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_HOLD  = 2'd2
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
// Single-clock FIFO with registered pointers and occupancy count.
// A pop is accepted only when not empty. A push is accepted when not full,
// or when full and a pop is accepted in the same cycle. When the FIFO is
// empty and both are requested, only the push takes effect.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, data_in   write request and data
//   pop             read request (head advances at the edge)
//   head            oldest entry (undefined contents when empty)
//   full, empty     occupancy flags
//   count           entries held, 0..DEPTH
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         data_in,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Storage is not reset; empty-ness is carried entirely by count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/serial_fifo_ctrl.sv
// serial_fifo_ctrl
// CPU-facing byte FIFO front end for a UART: an RX FIFO filled by the
// receiver and drained by CPU data reads, a TX FIFO filled by CPU data
// writes and drained by a small start/hold FSM into the transmitter, a
// status register, and a registered interrupt.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   enable_i, readEnable_i    one CPU access per high cycle; 1 = read
//   mode_i                    0 = data register, 1 = status register
//   dataSave_i, dataLoad_o    CPU write / read data (bytes in [7:0])
//   int_o                     interrupt: RX not empty or overrun
//   rxdReady_i, rxdData_i     received byte pulse and byte
//   txdBusy_i                 transmitter busy
//   txdStart_o, txdData_o     transmit start pulse and byte
//
// TX FSM
//   state    | meaning
//   ST_IDLE  | waiting for a queued byte and an idle transmitter
//   ST_START | one-cycle start pulse, head byte presented and popped
//   ST_HOLD  | one-cycle guard while the transmitter raises busy
module serial_fifo_ctrl
    import serial_fifo_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable_i,
    input  logic        readEnable_i,
    input  logic        mode_i,
    input  logic [31:0] dataSave_i,
    output logic [31:0] dataLoad_o,
    output logic        int_o,
    input  logic        rxdReady_i,
    input  logic [7:0]  rxdData_i,
    input  logic        txdBusy_i,
    output logic        txdStart_o,
    output logic [7:0]  txdData_o
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    tx_state_t        state;
    tx_state_t        state_nxt;

    logic             data_rd;
    logic             status_rd;
    logic             data_wr;

    logic [7:0]       rx_head;
    logic             rx_full;
    logic             rx_empty;
    logic [CNT_W-1:0] rx_count;
    logic             rx_pop_ok;

    logic [7:0]       tx_head;
    logic             tx_full;
    logic             tx_empty;
    logic [CNT_W-1:0] tx_count;
    logic             tx_pop;

    logic             overrun;
    logic             tx_idle;
    logic [7:0]       txd_last;
    logic [31:0]      status;
    logic             unused_bits;

    assign data_rd   = enable_i &&  readEnable_i && !mode_i;
    assign status_rd = enable_i &&  readEnable_i &&  mode_i;
    assign data_wr   = enable_i && !readEnable_i && !mode_i;

    assign rx_pop_ok   = data_rd && !rx_empty;
    assign unused_bits = ^{dataSave_i[31:8], rx_count, tx_count};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (rxdReady_i),
        .pop     (data_rd),
        .data_in (rxdData_i),
        .head    (rx_head),
        .full    (rx_full),
        .empty   (rx_empty),
        .count   (rx_count)
    );

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (data_wr),
        .pop     (tx_pop),
        .data_in (dataSave_i[7:0]),
        .head    (tx_head),
        .full    (tx_full),
        .empty   (tx_empty),
        .count   (tx_count)
    );

    // A byte arriving at a full FIFO is lost unless a read frees a slot in
    // the same cycle. A new overrun wins over a simultaneous status-read clear
    // so the event is never missed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (rxdReady_i && rx_full && !rx_pop_ok) begin
            overrun <= 1'b1;
        end else if (status_rd) begin
            overrun <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int_o <= 1'b0;
        end else begin
            int_o <= !rx_empty || overrun;
        end
    end

    assign tx_idle = tx_empty && (state == ST_IDLE) && !txdBusy_i;

    always_comb begin
        status         = 32'h0;
        status[TXNF]   = !tx_full;
        status[RXNE]   = !rx_empty;
        status[OVR]    = overrun;
        status[TXIDLE] = tx_idle;
    end

    always_comb begin
        dataLoad_o = 32'h0;
        if (data_rd) begin
            dataLoad_o = rx_empty ? 32'h0 : {24'h0, rx_head};
        end else if (status_rd) begin
            dataLoad_o = status;
        end
    end

    // TX FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // TX FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (!tx_empty && !txdBusy_i) state_nxt = ST_START;
            ST_START: state_nxt = ST_HOLD;
            ST_HOLD:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // TX FSM: outputs. Outside START the last handed-over byte is held.
    always_comb begin
        txdStart_o = (state == ST_START);
        tx_pop     = (state == ST_START);
        txdData_o  = (state == ST_START) ? tx_head : txd_last;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txd_last <= 8'h0;
        end else if (state == ST_START) begin
            txd_last <= tx_head;
        end
    end

endmodule

// File: tb/tb_serial_fifo_ctrl.sv
module tb_serial_fifo_ctrl;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable_i = 1'b0;
    logic        readEnable_i = 1'b0;
    logic        mode_i = 1'b0;
    logic [31:0] dataSave_i = 32'h0;
    logic [31:0] dataLoad_o;
    logic        int_o;
    logic        rxdReady_i = 1'b0;
    logic [7:0]  rxdData_i = 8'h0;
    logic        txdBusy_i = 1'b0;
    logic        txdStart_o;
    logic [7:0]  txdData_o;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_starts = 0;
    int          prev_n;
    logic        prev_start = 1'b0;
    logic [7:0]  rx_q[$];
    logic [7:0]  tx_q[$];
    logic        ovr_m = 1'b0;

    serial_fifo_ctrl #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable_i     (enable_i),
        .readEnable_i (readEnable_i),
        .mode_i       (mode_i),
        .dataSave_i   (dataSave_i),
        .dataLoad_o   (dataLoad_o),
        .int_o        (int_o),
        .rxdReady_i   (rxdReady_i),
        .rxdData_i    (rxdData_i),
        .txdBusy_i    (txdBusy_i),
        .txdStart_o   (txdStart_o),
        .txdData_o    (txdData_o)
    );

    always #20 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] status_exp(input logic tx_idle);
        status_exp = {28'h0, tx_idle, ovr_m, (rx_q.size() != 0), (tx_q.size() < DEPTH)};
    endfunction

    task automatic rx_pulse(input logic [7:0] b);
        @(negedge clk);
        rxdReady_i = 1'b1;
        rxdData_i  = b;
        if (rx_q.size() < DEPTH) rx_q.push_back(b);
        else ovr_m = 1'b1;
        @(posedge clk);
        #1 rxdReady_i = 1'b0;
    endtask

    task automatic data_read(input string tag);
        logic [31:0] exp;
        @(negedge clk);
        enable_i = 1'b1; readEnable_i = 1'b1; mode_i = 1'b0;
        #5;
        exp = (rx_q.size() != 0) ? {24'h0, rx_q.pop_front()} : 32'h0;
        chk(tag, dataLoad_o, exp);
        @(posedge clk);
        #1 enable_i = 1'b0; readEnable_i = 1'b0;
    endtask

    task automatic status_read(input string tag, input logic tx_idle);
        @(negedge clk);
        enable_i = 1'b1; readEnable_i = 1'b1; mode_i = 1'b1;
        #5;
        chk(tag, dataLoad_o, status_exp(tx_idle));
        ovr_m = 1'b0;
        @(posedge clk);
        #1 enable_i = 1'b0; readEnable_i = 1'b0; mode_i = 1'b0;
    endtask

    task automatic rx_and_read(input string tag, input logic [7:0] b);
        logic [31:0] exp;
        @(negedge clk);
        rxdReady_i = 1'b1; rxdData_i = b;
        enable_i = 1'b1; readEnable_i = 1'b1; mode_i = 1'b0;
        #5;
        exp = (rx_q.size() != 0) ? {24'h0, rx_q.pop_front()} : 32'h0;
        chk(tag, dataLoad_o, exp);
        rx_q.push_back(b);
        @(posedge clk);
        #1 rxdReady_i = 1'b0; enable_i = 1'b0; readEnable_i = 1'b0;
    endtask

    task automatic cpu_write(input logic [7:0] b);
        @(negedge clk);
        enable_i = 1'b1; readEnable_i = 1'b0; mode_i = 1'b0;
        dataSave_i = {24'hA5C3E1, b};
        tx_q.push_back(b);
        @(posedge clk);
        #1 enable_i = 1'b0;
    endtask

    task automatic wait_start(input string tag, input int prev);
        for (int i = 0; i < 30 && n_starts == prev; i++) @(negedge clk);
        chk(tag, 32'(n_starts != prev), 32'd1);
    endtask

    // Transmit-side monitor: every start must be a single-cycle pulse
    // carrying the oldest byte the CPU queued.
    always @(negedge clk) begin
        if (!rst && txdStart_o) begin
            chk("start_width", 32'(prev_start), 32'd0);
            chk("start_expected", 32'(tx_q.size() != 0), 32'd1);
            if (tx_q.size() != 0) chk("txd_data", 32'(txdData_o), 32'(tx_q.pop_front()));
            n_starts++;
        end
        prev_start = txdStart_o;
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_int", 32'(int_o), 32'd0);
        chk("rst_txdstart", 32'(txdStart_o), 32'd0);
        chk("rst_txddata", 32'(txdData_o), 32'd0);
        chk("rst_load", dataLoad_o, 32'd0);
        @(negedge clk) rst = 1'b0;

        status_read("rst_status", 1'b1);
        data_read("rst_data");

        // Two received bytes, interrupt latency, ordered reads
        rx_pulse(8'h41);
        chk("int_latency", 32'(int_o), 32'd0);
        @(posedge clk); #1;
        chk("int_set", 32'(int_o), 32'd1);
        rx_pulse(8'h42);
        chk("idle_load", dataLoad_o, 32'd0);
        data_read("rd_41");
        data_read("rd_42");
        @(posedge clk); #1;
        chk("int_clear", 32'(int_o), 32'd0);

        // Overflow: 17th byte dropped, sticky flag cleared by status read
        for (int i = 0; i < 17; i++) rx_pulse(8'h10 + 8'(i));
        status_read("ovr_status", 1'b1);
        status_read("ovr_cleared", 1'b1);
        chk("int_full", 32'(int_o), 32'd1);
        for (int i = 0; i < DEPTH; i++) data_read("drain_ovr");
        data_read("empty_read");

        // Full FIFO with simultaneous push and pop
        for (int i = 0; i < DEPTH; i++) rx_pulse(8'h60 + 8'(i));
        rx_and_read("full_push_pop", 8'hEE);
        status_read("no_ovr", 1'b1);
        rx_pulse(8'hEF);
        status_read("still_full", 1'b1);
        for (int i = 0; i < DEPTH; i++) data_read("drain_full");
        repeat (2) @(posedge clk);
        #1 chk("int_empty", 32'(int_o), 32'd0);

        // Empty FIFO with simultaneous push and pop
        rx_and_read("empty_push_pop", 8'h77);
        data_read("rd_77");

        // Back-to-back transmit
        prev_n = n_starts;
        cpu_write(8'h55);
        cpu_write(8'hAA);
        wait_start("tx_first", prev_n);
        wait_start("tx_second", prev_n + 1);
        repeat (5) @(posedge clk);
        #1 chk("txd_hold_aa", 32'(txdData_o), 32'h0AA);
        status_read("tx_done_status", 1'b1);

        // Transmitter busy stalls the second start
        prev_n = n_starts;
        cpu_write(8'h55);
        wait_start("stall_first", prev_n);
        txdBusy_i = 1'b1;
        cpu_write(8'hAA);
        repeat (10) @(negedge clk);
        chk("stall_held", 32'(n_starts), 32'(prev_n + 1));
        chk("txd_hold_55", 32'(txdData_o), 32'h055);
        status_read("busy_status", 1'b0);
        @(negedge clk) txdBusy_i = 1'b0;
        wait_start("stall_release", prev_n + 1);
        repeat (4) @(negedge clk);

        // Reset during HOLD with three bytes still queued
        txdBusy_i = 1'b1;
        cpu_write(8'hC1);
        cpu_write(8'hC2);
        cpu_write(8'hC3);
        cpu_write(8'hC4);
        @(negedge clk) txdBusy_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        tx_q.delete();
        rx_q.delete();
        ovr_m = 1'b0;
        chk("hold_no_start", 32'(txdStart_o), 32'd0);
        repeat (2) @(negedge clk);
        chk("rst_mid_txddata", 32'(txdData_o), 32'd0);
        rst = 1'b0;
        prev_n = n_starts;
        repeat (20) @(negedge clk);
        chk("no_restart", 32'(n_starts), 32'(prev_n));
        status_read("post_rst_status", 1'b1);
        chk("post_rst_int", 32'(int_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
